// File: rtl/mul_share_arbiter.sv
// Shares one pipelined signed multiplier among NREQ requesters and routes each product back by ID.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mul_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_m,
    output logic                  busy
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    valid_m;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic               accept;
    logic [MUL_LAT-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [MUL_LAT];

    // No grant may be offered while the block is held in reset.
    assign valid_m = rst_n ? req_valid : '0;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid_m[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_idx;
    logic           found;

    always_comb begin
        grant  = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && valid_m[rr_idx]) begin
                grant[rr_idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
`endif

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) grant_id = IDW'(i);
    end

    assign accept    = |grant;
    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= req_a[grant_id*WIDTH +: WIDTH];
            mul_b <= req_b[grant_id*WIDTH +: WIDTH];
        end
    end

    // Valid bits of the tag pipeline and the response strobe are cleared so reset discards in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld   <= '0;
            rsp_valid <= '0;
        end else begin
            tag_vld[0] <= accept;
            for (int i = 1; i < MUL_LAT; i++)
                tag_vld[i] <= tag_vld[i-1];
            rsp_valid <= tag_vld[MUL_LAT-1] ? (NREQ'(1) << tag_id[MUL_LAT-1]) : '0;
        end
    end

    // NOTE: the ID storage is deliberately not reset; its contents are only used when the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int i = 1; i < MUL_LAT; i++)
            tag_id[i] <= tag_id[i-1];
    end

    assign busy     = |tag_vld;
    assign rsp_data = mul_m;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one pipelined signed Booth multiplier (operands A/B, product M) among NREQ requesters. Each cycle it arbitrates among valid requests, issues at most one operand pair, and tracks the requester ID through the multiplier pipeline. It returns each product to its originator with a one-cycle response strobe. It sits between client datapaths and the multiplier instance.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH.
NREQ, 4, number of requesters, 2..8.
MUL_LAT, 2, multiplier latency in clocks from registered A/B to valid M, >=1.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
req_valid  in  NREQ  per-requester operand valid.
req_ready  out  NREQ  per-requester grant; combinational, one-hot or zero.
req_a  in  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
req_b  in  NREQ*WIDTH  packed operand B; same packing.
rsp_valid  out  NREQ  one-hot product strobe, 1 cycle.
rsp_data  out  2*WIDTH  product (signed A*B), valid while any rsp_valid bit is set.
mul_a  out  WIDTH  registered operand A to multiplier.
mul_b  out  WIDTH  registered operand B to multiplier.
mul_m  in  2*WIDTH  multiplier product.
busy  out  1  high while any issued operation is still in flight.

Behaviour:
- Reset (rst_n=0 at a clk edge): mul_a=0, mul_b=0, rr_ptr=0, tag pipeline cleared, rsp_valid=0, busy=0. req_ready=0 while rst_n=0.
- Reset mid-operation: in-flight products are discarded. No rsp_valid may fire for operations issued before reset.
- Arbitration: round-robin. Search starts at rr_ptr and wraps modulo NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1. At most one grant per cycle.
- Accept = req_valid[i] & req_ready[i] at edge T. On accept: mul_a/mul_b load req_a/req_b slice i; tag {1, i} enters the tag pipeline; rr_ptr becomes (i+1) mod NREQ.
- No request valid: rr_ptr holds. mul_a/mul_b hold their previous values. A bubble (valid=0) enters the tag pipeline.
- Tag pipeline: MUL_LAT stages of {valid, id[clog2(NREQ)-1:0]}, shifting every cycle, with no stall.
- Latency: accept at edge T gives rsp_valid[id]=1 in the cycle after edge T+MUL_LAT. That is MUL_LAT+1 cycles from the accept edge to the response being visible.
- Throughput: one operation per cycle sustained. Back-to-back accepts from different or the same requester produce back-to-back responses in issue order.
- rsp_data = mul_m passthrough. It is a don't-care when rsp_valid=0.
- Responses have no backpressure; requesters must capture in the strobe cycle.
- busy = OR of the tag pipeline valid bits.
- A requester that drops req_valid before grant is simply skipped. There is no lock or hold requirement.
- Product sign: operands are two's complement. rsp_data must equal $signed(A)*$signed(B) truncated to 2*WIDTH.

Optional Feature:
ARB_FIXED_PRIO_EN: defined -> fixed priority: the lowest index with req_valid wins; rr_ptr is removed/ignored. Undefined (default) -> round-robin as above. Latency, tagging and reset behaviour are identical in both modes.

Test Plan:
- Single request: req0 A=16'hFFFD (-3), B=16'h0005 accepted at T -> rsp_valid=4'b0001 at T+3 (MUL_LAT=2), rsp_data=32'hFFFF_FFF1; busy high for 2 cycles.
- All four requesters valid continuously, rr_ptr=0 -> grants 0,1,2,3,0,... one per cycle. Responses arrive in the same order, each with its own product (A=i+1, B=-(i+1) -> -1,-4,-9,-16).
- Fairness: req2 held valid, req0 pulses every other cycle -> neither starves; after a grant to 2, the next contention goes to 0.
- Reset mid-flight: 3 accepts then rst_n=0 for one edge -> no rsp_valid afterward, busy=0, mul_a=mul_b=0, next grant from requester 0.
- Corner operands: A=B=16'h8000 -> 32'h4000_0000; A=16'h7FFF, B=16'h8000 -> 32'hC000_8000; A=0, B=16'hFFFF -> 0.
- With ARB_FIXED_PRIO_EN: req1 and req3 both held valid -> req1 granted every cycle, req3 never granted until req1 drops.
